// File: rtl/seg_scan_pkg.sv
// Shared glyph codes and the 4-bit to 7-segment decode
// used by the multiplexed display scan driver.
package seg_scan_pkg;

  localparam logic [3:0] GLYPH_BLANK = 4'd10;
  localparam logic [3:0] GLYPH_DASH  = 4'd11;
  localparam logic [3:0] GLYPH_A     = 4'd12;
  localparam logic [3:0] GLYPH_P     = 4'd13;
  localparam logic [3:0] GLYPH_E     = 4'd14;
  localparam logic [3:0] GLYPH_R     = 4'd15;

  // Active-high segments, bit order {G,F,E,D,C,B,A}
  function automatic logic [6:0] glyph_decode(
    input logic [3:0] code
  );
    logic [6:0] g;
    case (code)
      4'd0:        g = 7'h3F;
      4'd1:        g = 7'h06;
      4'd2:        g = 7'h5B;
      4'd3:        g = 7'h4F;
      4'd4:        g = 7'h66;
      4'd5:        g = 7'h6D;
      4'd6:        g = 7'h7D;
      4'd7:        g = 7'h07;
      4'd8:        g = 7'h7F;
      4'd9:        g = 7'h6F;
      GLYPH_BLANK: g = 7'h00;
      GLYPH_DASH:  g = 7'h40;
      GLYPH_A:     g = 7'h77;
      GLYPH_P:     g = 7'h73;
      GLYPH_E:     g = 7'h79;
      GLYPH_R:     g = 7'h50;
      default:     g = 7'h00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder; polarity and DP are
// handled by the scan driver.
import seg_scan_pkg::*;

module seg_glyph_decode (
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  assign glyph = glyph_decode(code);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with dead-time,
// blink, leading-zero suppression and frame strobe.
import seg_scan_pkg::*;

module seg_scan_driver #(
  parameter int N_DIG          = 8,
  parameter int SCAN_TICKS     = 50000,
  parameter int BLANK_TICKS    = 500,
  parameter int BLINK_FRAMES   = 250,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               sclk,
  input  logic               nrst,
  input  logic [4*N_DIG-1:0] digits,
  input  logic [N_DIG-1:0]   dp_en,
  input  logic [N_DIG-1:0]   blink_en,
  input  logic               lz_blank,
  input  logic               disp_en,
  output logic [N_DIG-1:0]   sel,
  output logic [7:0]         seg,
  output logic               frame_start
);

  localparam int CW =
    (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int IW =
    (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_TICKS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  localparam logic [N_DIG-1:0] SEL_OFF = {N_DIG{SEL_ACTIVE_LOW}};
  localparam logic [7:0]       SEG_OFF = {8{SEG_ACTIVE_LOW}};

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [FW-1:0]      frm;
  logic               phase;

  logic [4*N_DIG-1:0] snap_dig;
  logic [N_DIG-1:0]   snap_dp;
  logic [N_DIG-1:0]   snap_blink;
  logic               snap_lz;

  logic               slot_end;
  logic               frame_end;
  logic               frame_go;

  logic [N_DIG-1:0]   supp;
  logic               run;
  logic [3:0]         cur_code;
  logic               cur_dp;
  logic               cur_blink;
  logic               cur_supp;
  logic [6:0]         cur_glyph;

  logic               lit;
  logic [N_DIG-1:0]   sel_on;
  logic [7:0]         seg_on;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign frame_go  = (cnt == '0) && (idx == '0);

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      idx   <= '0;
      frm   <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (frame_end) begin
        if (frm == FRM_LAST) begin
          frm   <= '0;
          phase <= ~phase;
        end else begin
          frm <= frm + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      snap_dig   <= '0;
      snap_dp    <= '0;
      snap_blink <= '0;
      snap_lz    <= 1'b0;
    end else if (frame_go) begin
      snap_dig   <= digits;
      snap_dp    <= dp_en;
      snap_blink <= blink_en;
      snap_lz    <= lz_blank;
    end
  end

  // Suppression runs down from the top digit; any nonzero
  // code or DP stops it, and digit 0 always stays visible.
  always_comb begin
    supp = '0;
    run  = snap_lz;
    for (int i = N_DIG - 1; i > 0; i--) begin
      run = run
        && (snap_dig[4*i +: 4] == 4'd0)
        && !snap_dp[i];
      supp[i] = run;
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = snap_dig[4*i +: 4];
        cur_dp    = snap_dp[i];
        cur_blink = snap_blink[i];
        cur_supp  = supp[i];
      end
    end
  end

  seg_glyph_decode u_glyph (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  always_comb begin
    lit = disp_en
      && (cnt >= CNT_BLANK)
      && !cur_supp
      && !(phase && cur_blink);
    sel_on = '0;
    seg_on = '0;
    if (lit) begin
      sel_on = N_DIG'(1) << idx;
      seg_on = {cur_dp, cur_glyph};
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      sel         <= SEL_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel_on ^ SEL_OFF;
      seg         <= seg_on ^ SEG_OFF;
      frame_start <= frame_go;
    end
  end

endmodule
